// File: rtl/mem_stage_lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - funct3 encodings for the RISC-V load/store access sizes
//   - FSM state encoding
//   - helper functions for load formatting, store lane placement,
//     byte-enable generation, misalignment and illegal funct3 detection
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } lsu_state_e;

   // Pick the addressed byte/halfword out of the read word and extend it.
   function automatic logic [31:0] load_format(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [31:0] b_sh;
      logic [31:0] h_sh;
      b_sh = rdata >> {off, 3'b000};
      h_sh = rdata >> {off[1], 4'b0000};
      case (f3)
         F3_B:    return {{24{b_sh[7]}}, b_sh[7:0]};
         F3_H:    return {{16{h_sh[15]}}, h_sh[15:0]};
         F3_BU:   return {24'h0, b_sh[7:0]};
         F3_HU:   return {16'h0, h_sh[15:0]};
         default: return rdata;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] off,
                                           input logic [2:0] f3);
      case (f3)
         F3_B:    return 4'b0001 << off;
         F3_H:    return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate the store data across every lane so the byte enables alone
   // select where it lands in memory.
   function automatic logic [31:0] store_lane(input logic [31:0] data,
                                              input logic [2:0]  f3);
      case (f3)
         F3_B:    return {4{data[7:0]}};
         F3_H:    return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] off,
                                       input logic [2:0] f3);
      case (f3)
         F3_H, F3_HU: return off[0];
         F3_W:        return off != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

   function automatic logic illegal_f3(input logic       is_load,
                                       input logic [2:0] f3);
      if (is_load)
         return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      else
         return !(f3 inside {F3_B, F3_H, F3_W});
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: req/ack data-memory bus between the LSU and memory.
//   dmem_req   request, held until ack
//   dmem_we    1 = store
//   dmem_addr  word-aligned address
//   dmem_wdata lane-replicated store data
//   dmem_be    byte enables
//   dmem_rdata read data, valid with ack
//   dmem_ack   one-cycle completion pulse
interface mem_stage_lsu_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_stage_lsu_timeout_ctr.sv
// lsu_timeout_ctr: counts cycles spent waiting for a bus ack.
//   clk, reset  clock and synchronous active-high reset
//   en          high while the LSU is waiting for an ack
//   expire      high in the last allowed waiting cycle
module lsu_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic expire
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The counter clears whenever the LSU is not waiting, so every new
   // transaction starts counting from zero.
   always_comb begin
      cnt_d  = en ? cnt_q + 1'b1 : '0;
      expire = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RISC-V MEM pipeline stage with a req/ack data-memory bus.
//   clk, reset            clock and synchronous active-high reset
//   ex_*                  instruction and operands from the EX/MEM register
//   dmem (master)         data-memory bus
//   mem_stall             freezes the upstream stages while a transaction waits
//   mem_*_mem, mem_inst   write-back triple and instruction for MEM/WB
//   mem_fault             pulse on misaligned access or illegal funct3
//   mem_bus_err           pulse when a transaction times out
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ex_valid,
   input  logic [31:0]            ex_inst,
   input  logic [31:0]            ex_alu_result,
   input  logic [31:0]            ex_store_data,
   input  logic [4:0]             ex_rd_addr,
   input  logic                   ex_rd_we,
   input  logic                   ex_mem_read,
   input  logic                   ex_mem_write,
   input  logic [2:0]             ex_funct3,
   mem_stage_lsu_if.master        dmem,
   output logic                   mem_stall,
   output logic [31:0]            mem_data_mem,
   output logic [4:0]             mem_addr_mem,
   output logic                   mem_we_mem,
   output logic [31:0]            mem_inst,
   output logic                   mem_fault,
   output logic                   mem_bus_err
);

   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  f3_q, f3_d;
   logic [4:0]  rd_q, rd_d;
   logic        rd_we_q, rd_we_d;
   logic [31:0] inst_q, inst_d;

   logic        expire;
   logic        mem_op;
   logic        fault;
   logic        req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [3:0]  bus_be_o;

   lsu_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .en     (state_q == WAIT_ACK),
      .expire (expire)
   );

   // Read and write together is not a real instruction, so it is reported
   // as a fault rather than guessing which one was meant.
   always_comb begin
      mem_op = ex_valid & (ex_mem_read | ex_mem_write);
      fault  = mem_op & ((ex_mem_read & ex_mem_write)
                         | illegal_f3(ex_mem_read, ex_funct3)
                         | misaligned(ex_alu_result[1:0], ex_funct3));
   end

   // Next-state, capture and output logic. Bus outputs come only from the
   // capture registers so they stay stable for the whole wait. Reset masks
   // every output at the end so nothing leaks while it is held.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      we_d         = we_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      f3_d         = f3_q;
      rd_d         = rd_q;
      rd_we_d      = rd_we_q;
      inst_d       = inst_q;
      req_o        = 1'b0;
      bus_we_o     = 1'b0;
      bus_addr_o   = '0;
      bus_wdata_o  = '0;
      bus_be_o     = '0;
      mem_stall    = 1'b0;
      mem_data_mem = '0;
      mem_addr_mem = '0;
      mem_we_mem   = 1'b0;
      mem_inst     = '0;
      mem_fault    = 1'b0;
      mem_bus_err  = 1'b0;

      case (state_q)
         IDLE: begin
            mem_addr_mem = ex_rd_addr;
            mem_inst     = ex_inst;
            if (!mem_op) begin
               mem_data_mem = ex_alu_result;
               mem_we_mem   = ex_rd_we & ex_valid;
            end else if (fault) begin
               mem_fault = 1'b1;
            end else begin
               mem_stall = 1'b1;
               addr_d    = ex_alu_result;
               we_d      = ex_mem_write;
               be_d      = ex_mem_write ? store_be(ex_alu_result[1:0], ex_funct3) : 4'b1111;
               wdata_d   = ex_mem_write ? store_lane(ex_store_data, ex_funct3) : '0;
               f3_d      = ex_funct3;
               rd_d      = ex_rd_addr;
               rd_we_d   = ex_rd_we;
               inst_d    = ex_inst;
               state_d   = WAIT_ACK;
            end
         end

         WAIT_ACK: begin
            req_o        = 1'b1;
            bus_we_o     = we_q;
            bus_addr_o   = {addr_q[31:2], 2'b00};
            bus_wdata_o  = wdata_q;
            bus_be_o     = be_q;
            mem_addr_mem = rd_q;
            mem_inst     = inst_q;
            if (dmem.dmem_ack) begin
               mem_data_mem = we_q ? '0 : load_format(dmem.dmem_rdata, addr_q[1:0], f3_q);
               mem_we_mem   = rd_we_q & ~we_q;
               state_d      = IDLE;
            end else if (expire) begin
               mem_bus_err = 1'b1;
               state_d     = IDLE;
            end else begin
               mem_stall = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      if (reset) begin
         req_o        = 1'b0;
         bus_we_o     = 1'b0;
         bus_addr_o   = '0;
         bus_wdata_o  = '0;
         bus_be_o     = '0;
         mem_stall    = 1'b0;
         mem_data_mem = '0;
         mem_addr_mem = '0;
         mem_we_mem   = 1'b0;
         mem_inst     = '0;
         mem_fault    = 1'b0;
         mem_bus_err  = 1'b0;
      end
   end

   assign dmem.dmem_req   = req_o;
   assign dmem.dmem_we    = bus_we_o;
   assign dmem.dmem_addr  = bus_addr_o;
   assign dmem.dmem_wdata = bus_wdata_o;
   assign dmem.dmem_be    = bus_be_o;

   // State and capture registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         rd_we_q <= 1'b0;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         rd_we_q <= rd_we_d;
         inst_q  <= inst_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed self-checking bench for mem_stage_lsu.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 3 units later, well away from the next active edge.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic [31:0] ex_inst;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd_addr;
   logic        ex_rd_we;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [2:0]  ex_funct3;
   logic        mem_stall;
   logic [31:0] mem_data_mem;
   logic [4:0]  mem_addr_mem;
   logic        mem_we_mem;
   logic [31:0] mem_inst;
   logic        mem_fault;
   logic        mem_bus_err;

   int checks = 0;
   int errors = 0;

   mem_stage_lsu_if bus ();

   mem_stage_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .ex_valid      (ex_valid),
      .ex_inst       (ex_inst),
      .ex_alu_result (ex_alu_result),
      .ex_store_data (ex_store_data),
      .ex_rd_addr    (ex_rd_addr),
      .ex_rd_we      (ex_rd_we),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_funct3     (ex_funct3),
      .dmem          (bus),
      .mem_stall     (mem_stall),
      .mem_data_mem  (mem_data_mem),
      .mem_addr_mem  (mem_addr_mem),
      .mem_we_mem    (mem_we_mem),
      .mem_inst      (mem_inst),
      .mem_fault     (mem_fault),
      .mem_bus_err   (mem_bus_err)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle_inputs();
      ex_valid      = 1'b0;
      ex_inst       = '0;
      ex_alu_result = '0;
      ex_store_data = '0;
      ex_rd_addr    = '0;
      ex_rd_we      = 1'b0;
      ex_mem_read   = 1'b0;
      ex_mem_write  = 1'b0;
      ex_funct3     = '0;
      bus.dmem_ack  = 1'b0;
      bus.dmem_rdata = '0;
   endtask

   task automatic drive_mem(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [4:0] rda, input logic rdwe);
      ex_valid      = 1'b1;
      ex_inst       = 32'h0000_0003;
      ex_alu_result = addr;
      ex_store_data = sdata;
      ex_rd_addr    = rda;
      ex_rd_we      = rdwe;
      ex_mem_read   = rd;
      ex_mem_write  = wr;
      ex_funct3     = f3;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      ex_valid = 1'b1; ex_alu_result = 32'h55; ex_rd_addr = 5'd4; ex_rd_we = 1'b1; ex_inst = 32'h33;
      next_cycle();
      settle();
      checks++; if (mem_data_mem !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", mem_data_mem); end
      checks++; if (mem_we_mem !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b want 0", mem_we_mem); end
      checks++; if (mem_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h want 0", mem_inst); end
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b want 0", bus.dmem_req); end
      next_cycle();
      reset = 1'b0;
      idle_inputs();
   endtask

   task automatic test_alu_pass();
      next_cycle();
      ex_valid = 1'b1; ex_alu_result = 32'h0000_1234; ex_rd_addr = 5'd5; ex_rd_we = 1'b1; ex_inst = 32'h0062_82B3;
      settle();
      checks++; if (mem_data_mem !== 32'h1234) begin errors++; $display("[TB] FAIL alu_data: got %h want 1234", mem_data_mem); end
      checks++; if (mem_addr_mem !== 5'd5) begin errors++; $display("[TB] FAIL alu_rd: got %0d want 5", mem_addr_mem); end
      checks++; if (mem_we_mem !== 1'b1) begin errors++; $display("[TB] FAIL alu_we: got %b want 1", mem_we_mem); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall: got %b want 0", mem_stall); end
      checks++; if (mem_inst !== 32'h0062_82B3) begin errors++; $display("[TB] FAIL alu_inst: got %h want 006282b3", mem_inst); end
      next_cycle();
      idle_inputs();
      settle();
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL alu_req: got %b want 0", bus.dmem_req); end
   endtask

   task automatic test_lb();
      next_cycle();
      drive_mem(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
      settle();
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("[TB] FAIL lb_issue_stall: got %b want 1", mem_stall); end
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL lb_issue_req: got %b want 0", bus.dmem_req); end
      next_cycle();
      settle();
      checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL lb_req: got %b want 1", bus.dmem_req); end
      checks++; if (bus.dmem_addr !== 32'h100) begin errors++; $display("[TB] FAIL lb_addr: got %h want 100", bus.dmem_addr); end
      checks++; if (bus.dmem_be !== 4'b1111) begin errors++; $display("[TB] FAIL lb_be: got %b want 1111", bus.dmem_be); end
      checks++; if (mem_stall !== 1'b1 || mem_we_mem !== 1'b0) begin errors++; $display("[TB] FAIL lb_wait1: stall %b we %b want 1 0", mem_stall, mem_we_mem); end
      next_cycle();
      settle();
      checks++; if (mem_stall !== 1'b1 || bus.dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL lb_wait2: stall %b req %b want 1 1", mem_stall, bus.dmem_req); end
      next_cycle();
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h80FF_0000;
      settle();
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("[TB] FAIL lb_ack_stall: got %b want 0", mem_stall); end
      checks++; if (mem_data_mem !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL lb_data: got %h want ffffff80", mem_data_mem); end
      checks++; if (mem_we_mem !== 1'b1 || mem_addr_mem !== 5'd7) begin errors++; $display("[TB] FAIL lb_wb: we %b rd %0d want 1 7", mem_we_mem, mem_addr_mem); end
      next_cycle();
      idle_inputs();
      settle();
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL lb_done_req: got %b want 0", bus.dmem_req); end
   endtask

   task automatic test_half_and_store();
      // LHU 0x102: upper halfword, zero-extended
      next_cycle();
      drive_mem(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd8, 1'b1);
      next_cycle();
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h8001_0000;
      settle();
      checks++; if (mem_data_mem !== 32'h0000_8001) begin errors++; $display("[TB] FAIL lhu_data: got %h want 00008001", mem_data_mem); end
      checks++; if (mem_we_mem !== 1'b1) begin errors++; $display("[TB] FAIL lhu_we: got %b want 1", mem_we_mem); end
      next_cycle();
      idle_inputs();
      // LH 0x100: lower halfword, sign-extended
      next_cycle();
      drive_mem(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 5'd9, 1'b1);
      next_cycle();
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1234_8001;
      settle();
      checks++; if (mem_data_mem !== 32'hFFFF_8001) begin errors++; $display("[TB] FAIL lh_data: got %h want ffff8001", mem_data_mem); end
      next_cycle();
      idle_inputs();
      // SH 0x102
      next_cycle();
      drive_mem(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd0, 1'b0);
      next_cycle();
      settle();
      checks++; if (bus.dmem_be !== 4'b1100) begin errors++; $display("[TB] FAIL sh_be: got %b want 1100", bus.dmem_be); end
      checks++; if (bus.dmem_wdata !== 32'hABCD_ABCD) begin errors++; $display("[TB] FAIL sh_wdata: got %h want abcdabcd", bus.dmem_wdata); end
      checks++; if (bus.dmem_we !== 1'b1 || bus.dmem_addr !== 32'h100) begin errors++; $display("[TB] FAIL sh_bus: we %b addr %h want 1 100", bus.dmem_we, bus.dmem_addr); end
      next_cycle();
      bus.dmem_ack = 1'b1;
      settle();
      checks++; if (mem_we_mem !== 1'b0 || mem_stall !== 1'b0 || mem_data_mem !== 32'h0) begin errors++; $display("[TB] FAIL sh_ack: we %b stall %b data %h want 0 0 0", mem_we_mem, mem_stall, mem_data_mem); end
      next_cycle();
      idle_inputs();
      // SB 0x101
      next_cycle();
      drive_mem(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_565A, 5'd0, 1'b0);
      next_cycle();
      settle();
      checks++; if (bus.dmem_be !== 4'b0010 || bus.dmem_wdata !== 32'h5A5A_5A5A) begin errors++; $display("[TB] FAIL sb_bus: be %b wdata %h want 0010 5a5a5a5a", bus.dmem_be, bus.dmem_wdata); end
      bus.dmem_ack = 1'b1;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_fault();
      next_cycle();
      drive_mem(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd3, 1'b1);
      settle();
      checks++; if (mem_fault !== 1'b1) begin errors++; $display("[TB] FAIL lw_mis_fault: got %b want 1", mem_fault); end
      checks++; if (mem_stall !== 1'b0 || mem_we_mem !== 1'b0) begin errors++; $display("[TB] FAIL lw_mis_wb: stall %b we %b want 0 0", mem_stall, mem_we_mem); end
      next_cycle();
      drive_mem(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd3, 1'b1);
      settle();
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL lw_mis_req: got %b want 0", bus.dmem_req); end
      checks++; if (mem_fault !== 1'b1) begin errors++; $display("[TB] FAIL f3_011_fault: got %b want 1", mem_fault); end
      next_cycle();
      drive_mem(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd3, 1'b1);
      settle();
      checks++; if (mem_fault !== 1'b1) begin errors++; $display("[TB] FAIL rdwr_fault: got %b want 1", mem_fault); end
      next_cycle();
      idle_inputs();
      settle();
      checks++; if (mem_fault !== 1'b0 || bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL fault_after: fault %b req %b want 0 0", mem_fault, bus.dmem_req); end
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      int stall_cycles = 0;
      int err_idx = -1;
      int we_seen = 0;
      next_cycle();
      drive_mem(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd3, 1'b1);
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         settle();
         if (bus.dmem_req !== 1'b1) break;
         req_cycles++;
         if (mem_stall === 1'b1) stall_cycles++;
         if (mem_we_mem !== 1'b0) we_seen++;
         if (mem_bus_err === 1'b1) begin
            err_idx = i;
            idle_inputs();
         end
      end
      checks++; if (req_cycles != 16) begin errors++; $display("[TB] FAIL to_req_cycles: got %0d want 16", req_cycles); end
      checks++; if (err_idx != 15) begin errors++; $display("[TB] FAIL to_err_cycle: got %0d want 15", err_idx); end
      checks++; if (stall_cycles != 15 || we_seen != 0) begin errors++; $display("[TB] FAIL to_stall: stall %0d we %0d want 15 0", stall_cycles, we_seen); end
      checks++; if (mem_bus_err !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("[TB] FAIL to_after: err %b stall %b want 0 0", mem_bus_err, mem_stall); end
      idle_inputs();
   endtask

   task automatic test_ack_at_timeout();
      next_cycle();
      drive_mem(1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0, 5'd11, 1'b1);
      for (int i = 0; i < 16; i++) begin
         next_cycle();
         if (i == 15) begin
            bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1234_5678;
         end
         settle();
      end
      checks++; if (mem_bus_err !== 1'b0) begin errors++; $display("[TB] FAIL ackto_err: got %b want 0", mem_bus_err); end
      checks++; if (mem_data_mem !== 32'h1234_5678 || mem_we_mem !== 1'b1) begin errors++; $display("[TB] FAIL ackto_wb: data %h we %b want 12345678 1", mem_data_mem, mem_we_mem); end
      next_cycle();
      idle_inputs();
      settle();
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL ackto_req: got %b want 0", bus.dmem_req); end
   endtask

   task automatic test_reset_mid();
      next_cycle();
      drive_mem(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd9, 1'b1);
      next_cycle();
      settle();
      checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rm_req_before: got %b want 1", bus.dmem_req); end
      next_cycle();
      reset = 1'b1;
      settle();
      checks++; if (bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("[TB] FAIL rm_forced: req %b stall %b want 0 0", bus.dmem_req, mem_stall); end
      next_cycle();
      reset = 1'b0;
      idle_inputs();
      settle();
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL rm_req_after: got %b want 0", bus.dmem_req); end
      next_cycle();
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
      settle();
      checks++; if (mem_we_mem !== 1'b0 || mem_data_mem !== 32'h0 || mem_stall !== 1'b0) begin errors++; $display("[TB] FAIL rm_stray_ack: we %b data %h stall %b want 0 0 0", mem_we_mem, mem_data_mem, mem_stall); end
      next_cycle();
      idle_inputs();
      settle();
      checks++; if (bus.dmem_req !== 1'b0 || mem_we_mem !== 1'b0) begin errors++; $display("[TB] FAIL rm_idle: req %b we %b want 0 0", bus.dmem_req, mem_we_mem); end
   endtask

   initial begin
      $display("[TB] mem_stage_lsu directed tests");
      test_reset();
      test_alu_pass();
      test_lb();
      test_half_and_store();
      test_fault();
      test_timeout();
      test_ack_at_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM pipeline stage, between the EX/MEM register and the MEM/WB register (reg_MEM_WB).
- Executes RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a req/ack data-memory bus.
- Formats load data and produces the write-back triple (data, rd address, write-enable) consumed by MEM/WB.
- Stalls upstream stages while a memory transaction is outstanding; flags misaligned/illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, cycles in WAIT_ACK before the access is abandoned (range 2..255).
- CNT_W, 8, width of the timeout counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_inst  in  32  instruction word, passed through
- ex_alu_result  in  32  effective address, or ALU result for non-memory ops
- ex_store_data  in  32  rs2 value for stores
- ex_rd_addr  in  5  destination register
- ex_rd_we  in  1  instruction writes rd
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  one-cycle completion pulse
- mem_stall  out  1  freeze PC/IF/ID/EX/EX-MEM
- mem_data_mem  out  32  to MEM/WB data
- mem_addr_mem  out  5  to MEM/WB rd address
- mem_we_mem  out  1  to MEM/WB write-enable
- mem_inst  out  32  to MEM/WB instruction
- mem_fault  out  1  one-cycle pulse: misaligned or illegal funct3
- mem_bus_err  out  1  one-cycle pulse: timeout

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE, counter=0, captured request registers=0. While reset is high, all outputs are forced to 0.
- Reset mid-transaction: drops dmem_req on the next edge. A later stray ack in IDLE is ignored.
- Access decode: mem_op = ex_valid & (ex_mem_read | ex_mem_write). ex_mem_read and ex_mem_write both set is treated as illegal.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
- Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
- Faulted op: no bus request; mem_fault=1 for one cycle; mem_we_mem=0; no stall.
- Non-memory op (IDLE): zero-latency combinational pass-through. mem_data_mem=ex_alu_result, mem_addr_mem=ex_rd_addr, mem_we_mem=ex_rd_we&ex_valid, mem_stall=0.
- States: IDLE, WAIT_ACK.
- IDLE, legal mem_op: capture addr/we/be/wdata/funct3/rd/rd_we/inst; dmem_req=1 from the next cycle; mem_stall=1 combinationally this cycle; go to WAIT_ACK.
- WAIT_ACK: dmem_req=1 and all bus outputs held stable from the capture registers. mem_stall=1 except in the ack cycle.
- WAIT_ACK, ack=1: mem_stall=0; mem_data_mem=formatted load data (stores: 0); mem_we_mem=captured rd_we & load; mem_addr_mem/mem_inst from the capture registers; go to IDLE. Minimum load/store latency is 2 cycles (issue + ack).
- WAIT_ACK, no ack: counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ack: drop req, mem_bus_err pulse, mem_stall=0 that cycle, mem_we_mem=0, go to IDLE.
- Ack and timeout in the same cycle: ack wins.
- Stall cycles: mem_we_mem=0 (bubble into MEM/WB).
- Load formatting: byte lane = addr[1:0], halfword lane = addr[1].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: as-is.
- Store formatting:
  - SB: wdata={4{b}}, be=1<<addr[1:0].
  - SH: wdata={2{h}}, be = addr[1] ? 1100 : 0011.
  - SW: be=1111.
  - Loads: be=1111, wdata=0.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B/H/W/BU/HU)
  - state encoding
  - functions: load_format(rdata, off, f3), store_be(off, f3), store_lane(data, f3), misaligned(off, f3)
- Optional sub-module lsu_timeout_ctr (counter + expire).
- Everything else stays inline.

Test Plan:
- ADD x5, ex_alu_result=0x0000_1234, rd_we=1 -> same cycle mem_data_mem=0x1234, mem_addr_mem=5, mem_we_mem=1, mem_stall=0, dmem_req never set.
- LB addr=0x103, rdata=0x80FF_0000 with ack 3 cycles after req -> dmem_addr=0x100, stall high 3 cycles, ack cycle mem_data_mem=0xFFFF_FF80, mem_we_mem=1.
- LHU addr=0x102, rdata=0x8001_0000, ack next cycle -> mem_data_mem=0x0000_8001. SH addr=0x102 data=0xABCD -> be=1100, wdata=0xABCD_ABCD, mem_we_mem=0.
- LW addr=0x101 -> mem_fault pulse, dmem_req=0, mem_we_mem=0, mem_stall=0. LB with funct3=011 -> mem_fault pulse.
- LW with no ack, TIMEOUT_CYCLES=16 -> req held 16 cycles, mem_bus_err pulse, req drops, back to IDLE. Ack on that same final cycle instead -> normal completion, no mem_bus_err.
- reset asserted during WAIT_ACK -> next cycle dmem_req=0, outputs 0. Ack pulse after reset release -> ignored, no writeback.
